// File: rtl/pc_pkg.sv
// Shared definitions for the program counter and its return-address stack.
// Holds the operation encoding and the fixed-priority request encoder.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_INC  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_JMP  = 3'd4,
        OP_CALL = 3'd5,
        OP_RET  = 3'd6
    } op_e;

    // Only one operation runs per cycle. The highest-priority request is
    // chosen and the rest are dropped. Priority: ret > call > jmp > sub >
    // add > inc.
    function automatic op_e prio_encode(
        input logic i_ret,
        input logic i_call,
        input logic i_jmp,
        input logic i_sub,
        input logic i_add,
        input logic i_inc
    );
        op_e v_op;
        if (i_ret)       v_op = OP_RET;
        else if (i_call) v_op = OP_CALL;
        else if (i_jmp)  v_op = OP_JMP;
        else if (i_sub)  v_op = OP_SUB;
        else if (i_add)  v_op = OP_ADD;
        else if (i_inc)  v_op = OP_INC;
        else             v_op = OP_NONE;
        return v_op;
    endfunction

endpackage

// File: rtl/pc_rstack.sv
// Return-address LIFO: DEPTH entries of WIDTH bits.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous active-low reset (clears level only)
//   i_push   write i_data at the current level (ignored when full)
//   i_pop    drop the top entry (ignored when empty)
//   i_data   value to push
//   o_top    combinational top-of-stack (entry level-1)
//   o_level  number of valid entries
//   o_full   level == DEPTH
//   o_empty  level == 0
// i_push and i_pop are never asserted together.
module pc_rstack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    w_level_dec;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full      = (r_level == LW'(DEPTH));
    assign o_empty     = (r_level == '0);
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;
    assign w_level_dec = r_level - 1'b1;
    assign w_wr_idx    = r_level[AW-1:0];
    assign w_top_idx   = w_level_dec[AW-1:0];
    // When empty this reads a stale entry; nobody uses it in that case.
    assign o_top       = r_mem[w_top_idx];
    assign o_level     = r_level;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_level <= '0;
        end else if (w_do_push) begin
            r_level <= r_level + 1'b1;
        end else if (w_do_pop) begin
            r_level <= w_level_dec;
        end
    end

    // Storage has no reset: contents are invisible while level is 0.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware return-address stack, driving the fetch
// address every cycle.
// Ports:
//   i_clk     rising-edge clock
//   i_reset   synchronous active-low reset
//   i_inc     pc <- pc + 1
//   i_add     pc <- pc + offset
//   i_sub     pc <- pc - offset
//   i_jmp     pc <- offset
//   i_call    push pc + 1, pc <- offset
//   i_ret     pop, pc <- popped value
//   i_offset  branch offset / absolute target
//   o_pc      registered program counter
//   o_level   valid stack entries
//   o_full    stack full
//   o_empty   stack empty
//   o_err     sticky call-when-full / ret-when-empty flag
module pc_stack
    import pc_pkg::*;
#(
    parameter int              WIDTH     = 16,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    localparam int             LW        = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_add,
    input  logic             i_sub,
    input  logic             i_jmp,
    input  logic             i_call,
    input  logic             i_ret,
    input  logic [WIDTH-1:0] i_offset,
    output logic [WIDTH-1:0] o_pc,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_err
);

    logic [WIDTH-1:0] r_pc;
    logic             r_err;
    op_e              w_op;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_operand;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_err_set;
    logic             w_push;
    logic             w_pop;
    logic             w_subtract;

    assign w_op = prio_encode(i_ret, i_call, i_jmp, i_sub, i_add, i_inc);

    // One adder for add and sub: subtract is pc + ~offset + 1.
    assign w_subtract = (w_op == OP_SUB);
    assign w_operand  = w_subtract ? ~i_offset : i_offset;
    assign w_sum      = r_pc + w_operand + {{(WIDTH-1){1'b0}}, w_subtract};
    assign w_pc_inc   = r_pc + {{(WIDTH-1){1'b0}}, 1'b1};

    assign w_push = (w_op == OP_CALL);
    assign w_pop  = (w_op == OP_RET);

    pc_rstack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rstack (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_level (o_level),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    always_comb begin
        w_pc_next = r_pc;
        w_err_set = 1'b0;
        unique case (w_op)
            OP_INC:  w_pc_next = w_pc_inc;
            OP_ADD,
            OP_SUB:  w_pc_next = w_sum;
            OP_JMP:  w_pc_next = i_offset;
            OP_CALL: begin
                if (o_full) w_err_set = 1'b1;
                else        w_pc_next = i_offset;
            end
            OP_RET: begin
                if (o_empty) w_err_set = 1'b1;
                else         w_pc_next = w_top;
            end
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc  <= RESET_VEC;
            r_err <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign o_pc  = r_pc;
    assign o_err = r_err;

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with a hardware return-address stack, successor to the fixed 16-bit PC. It supports increment, relative forward/backward branch, absolute jump, call (push return address) and return (pop). Over/underflow is detected and flagged. It sits at the head of the fetch path and drives the instruction-memory address every cycle.

## Interface
- WIDTH, 16, PC/offset/target width in bits (≥ 2)
- DEPTH, 4, return-stack entries (power of two, ≥ 2)
- RESET_VEC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock, sole clock
- reset  in  1  synchronous, active-low reset
- inc  in  1  pc ← pc + 1
- add  in  1  pc ← pc + offset
- sub  in  1  pc ← pc − offset
- jmp  in  1  pc ← offset (absolute)
- call  in  1  push pc + 1; pc ← offset
- ret  in  1  pop; pc ← popped value
- offset  in  WIDTH  branch offset or absolute target
- pc  out  WIDTH  current program counter (registered)
- level  out  $clog2(DEPTH)+1  number of valid stack entries
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- err  out  1  sticky: set on call-when-full or ret-when-empty

## Operation
- Exactly one operation is performed per cycle. Fixed priority: ret > call > jmp > sub > add > inc. Lower-priority requests in the same cycle are ignored, not queued.
- No request asserted: pc holds.
- All arithmetic is modulo 2^WIDTH. Wrap-around is silent: pc = 2^WIDTH−1 with inc gives 0, and pc = 0 with sub offset 1 gives 2^WIDTH−1.
- call, not full:
  - stack[level] ← pc + 1 (mod 2^WIDTH)
  - level + 1
  - pc ← offset
- call when full: no push, pc holds, err ← 1.
- ret, not empty:
  - pc ← stack[level−1]
  - level − 1
- ret when empty: pc holds, level stays 0, err ← 1.
- err clears only on reset.
- full and empty are combinational decodes of the level register.

## Timing
- All state updates on the rising edge of clk. pc, level and err are registered.
- Effect of a request is visible on pc the cycle after it is sampled (1-cycle latency). Requests are sampled every cycle with no handshake and no stall.
- Back-to-back operations are supported:
  - call then ret on consecutive cycles returns to the call site + 1.
  - Consecutive calls fill the stack one entry per cycle.
- Reset (reset == 0 at a rising edge) overrides every request:
  - pc ← RESET_VEC, level ← 0, err ← 0.
  - Stack storage contents are not reset and are unobservable, since level = 0.
- Reset mid-sequence (e.g. with entries on the stack) discards all entries. The first ret after reset flags err.

## Structure
- Shared package pc_pkg holds:
  - the op priority encoding (enum: OP_NONE, OP_INC, OP_ADD, OP_SUB, OP_JMP, OP_CALL, OP_RET)
  - a priority-encode function mapping the six request bits to the enum
- Sub-module pc_rstack:
  - LIFO of DEPTH × WIDTH with push/pop/level/full/empty
  - push and pop are never asserted together
  - exports its top-of-stack combinationally
- Top level contains:
  - the op decode
  - the next-pc mux (pc+1, pc+offset, pc−offset, offset, top)
  - the pc and err registers
  - add and sub share one adder with a subtract control, as in the prior design.

## Test plan
Configuration for all scenarios: WIDTH=16, DEPTH=4, RESET_VEC=16'h0100.
- Reset then three cycles of inc → pc = 0x0100, 0x0101, 0x0102, 0x0103; level = 0; empty = 1; err = 0.
- pc = 0x0200:
  - add offset 0x0010 → 0x0210
  - then sub offset 0x0300 → 0xFF10 (wrap)
  - then inc at pc = 0xFFFF → 0x0000
- pc = 0x0100: call 0x0400, then call 0x0800, then ret, then ret:
  - pc = 0x0400, 0x0800, 0x0401, 0x0101
  - level = 1, 2, 1, 0
- Four calls fill the stack (full = 1), then a fifth call 0x0900 → pc unchanged, level stays 4, err = 1. err stays 1 through subsequent valid rets until reset.
- inc, add, jmp and ret all asserted with level = 1 and top = 0x0333 → pc = 0x0333 (ret wins). Same requests with level = 0 → pc holds, err = 1.
- Two calls (level = 2), then reset low for one cycle while call is asserted → pc = 0x0100, level = 0, err = 0. The next ret sets err.
